riscv_v_shift_seq: RTL and testbench

RISCV_V_SHIFT_SEQ -- requirements
Module: riscv_v_shift_seq

---
 rtl/riscv_v_pkg.sv | 39 +++
 rtl/riscv_v_osize_decode.sv | 35 +++
 rtl/riscv_v_shift_seq.sv | 174 +++++++++++++++++
 tb/tb_riscv_v_shift_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector shift sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH       = 128;
  localparam int RISCV_V_NUM_VALID_OSIZES = 5;
  // Pass counter covers up to eight register groups (LMUL=8).
  localparam int RISCV_V_PASS_WIDTH       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

  // LMUL field encoding: number of passes is 2^lmul.
  typedef enum logic [1:0] {
    LMUL_1 = 2'd0,
    LMUL_2 = 2'd1,
    LMUL_4 = 2'd2,
    LMUL_8 = 2'd3
  } lmul_e;

  // Index of the final pass for a given LMUL encoding.
  function automatic logic [RISCV_V_PASS_WIDTH-1:0] lmul_last_pass(input logic [1:0] lmul);
    logic [RISCV_V_PASS_WIDTH-1:0] last;
    case (lmul_e'(lmul))
      LMUL_1:  last = 3'd0;
      LMUL_2:  last = 3'd1;
      LMUL_4:  last = 3'd3;
      LMUL_8:  last = 3'd7;
      default: last = 3'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/riscv_v_osize_decode.sv
// Legalises the one-hot element size and builds the "size index >= k" vector.
// Latency: combinational.
// Backpressure: n/a.
module riscv_v_osize_decode
  import riscv_v_pkg::*;
#(
  parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
  input  logic [NUM_OSIZES-1:0] osize_raw,
  output logic [NUM_OSIZES-1:0] osize_onehot,
  output logic [NUM_OSIZES-1:0] osize_greater
);

  localparam logic [NUM_OSIZES-1:0] OSIZE_ONE = NUM_OSIZES'(1);

  logic is_onehot;

  // Anything that is not exactly one bit set falls back to the smallest element size.
  always_comb begin
    is_onehot    = (osize_raw != '0) && ((osize_raw & (osize_raw - OSIZE_ONE)) == '0);
    osize_onehot = is_onehot ? osize_raw : OSIZE_ONE;
  end

  // Bit k is set when the selected size index is k or larger: OR-reduce from the top down.
  always_comb begin
    logic acc;
    acc           = 1'b0;
    osize_greater = '0;
    for (int k = NUM_OSIZES - 1; k >= 0; k--) begin
      acc              = acc | osize_onehot[k];
      osize_greater[k] = acc;
    end
  end

endmodule

// File: rtl/riscv_v_shift_seq.sv
// Sequences a vector shift over 2^lmul register passes: read, shift, write back (macro RISCV_V_SHIFT_SEQ_PERF_CNT_EN adds a busy-cycle counter).
// Latency: first wb_valid 3 cycles after accept; each pass costs 3 cycles plus writeback stalls.
// Backpressure: req_ready only in IDLE; wb_valid/wb_data/wb_addr/wb_last hold until wb_ready.
module riscv_v_shift_seq
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH     = RISCV_V_DATA_WIDTH,
  parameter int NUM_OSIZES     = RISCV_V_NUM_VALID_OSIZES,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_left,
  input  logic                      req_is_arith,
  input  logic [NUM_OSIZES-1:0]     req_osize,
  input  logic [1:0]                req_lmul,
  input  logic [REG_ADDR_WIDTH-1:0] req_vd,
  input  logic [REG_ADDR_WIDTH-1:0] req_vs1,
  input  logic [REG_ADDR_WIDTH-1:0] req_vs2,
  output logic                      rf_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_a,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_b,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_a,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_b,
  output logic                      sh_is_shift,
  output logic                      sh_is_left,
  output logic                      sh_is_arith,
  output logic [NUM_OSIZES-1:0]     sh_osize_vector,
  output logic [NUM_OSIZES-1:0]     sh_is_greater_osize_vector,
  output logic [DATA_WIDTH-1:0]     sh_srca,
  output logic [DATA_WIDTH-1:0]     sh_srcb,
  input  logic [DATA_WIDTH-1:0]     sh_result,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_last,
  output logic                      busy
`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]               perf_busy_cycles
`endif
);

  seq_state_e                    state_q;
  logic [RISCV_V_PASS_WIDTH-1:0] pass_q;
  logic [RISCV_V_PASS_WIDTH-1:0] pass_nxt;
  logic                          is_last_pass;

  // Instruction fields captured at accept; osize is stored already legalised.
  logic                      is_left_q;
  logic                      is_arith_q;
  logic [1:0]                lmul_q;
  logic [REG_ADDR_WIDTH-1:0] vd_q;
  logic [REG_ADDR_WIDTH-1:0] vs1_q;
  logic [REG_ADDR_WIDTH-1:0] vs2_q;
  logic [NUM_OSIZES-1:0]     osize_q;
  logic [NUM_OSIZES-1:0]     greater_q;

  logic [NUM_OSIZES-1:0] dec_onehot;
  logic [NUM_OSIZES-1:0] dec_greater;

  riscv_v_osize_decode #(
    .NUM_OSIZES (NUM_OSIZES)
  ) u_osize_decode (
    .osize_raw     (req_osize),
    .osize_onehot  (dec_onehot),
    .osize_greater (dec_greater)
  );

  assign pass_nxt     = pass_q + 3'd1;
  assign is_last_pass = (pass_q == lmul_last_pass(lmul_q));

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  // Shifter sees operands only while executing so it stays quiet otherwise.
  always_comb begin
    sh_is_shift                = (state_q == ST_EXEC);
    sh_is_left                 = is_left_q;
    sh_is_arith                = is_arith_q;
    sh_osize_vector            = osize_q;
    sh_is_greater_osize_vector = greater_q;
    sh_srca                    = sh_is_shift ? rf_rd_data_a : '0;
    sh_srcb                    = sh_is_shift ? rf_rd_data_b : '0;
  end

  // Main sequencer: capture, one-cycle register read, shift capture, held writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pass_q       <= '0;
      is_left_q    <= 1'b0;
      is_arith_q   <= 1'b0;
      lmul_q       <= '0;
      vd_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      osize_q      <= '0;
      greater_q    <= '0;
      rf_rd_en     <= 1'b0;
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      wb_last      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            is_left_q    <= req_is_left;
            is_arith_q   <= req_is_arith;
            lmul_q       <= req_lmul;
            vd_q         <= req_vd;
            vs1_q        <= req_vs1;
            vs2_q        <= req_vs2;
            osize_q      <= dec_onehot;
            greater_q    <= dec_greater;
            pass_q       <= '0;
            rf_rd_en     <= 1'b1;
            rf_rd_addr_a <= req_vs1;
            rf_rd_addr_b <= req_vs2;
            state_q      <= ST_READ;
          end
        end
        ST_READ: begin
          // Read data arrives during EXEC; strobe is a single cycle.
          rf_rd_en <= 1'b0;
          state_q  <= ST_EXEC;
        end
        ST_EXEC: begin
          wb_data  <= sh_result;
          wb_addr  <= vd_q + REG_ADDR_WIDTH'(pass_q);
          wb_last  <= is_last_pass;
          wb_valid <= 1'b1;
          state_q  <= ST_WB;
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (is_last_pass) begin
              state_q <= ST_IDLE;
            end else begin
              // Register indices wrap naturally at the address width.
              pass_q       <= pass_nxt;
              rf_rd_en     <= 1'b1;
              rf_rd_addr_a <= vs1_q + REG_ADDR_WIDTH'(pass_nxt);
              rf_rd_addr_b <= vs2_q + REG_ADDR_WIDTH'(pass_nxt);
              state_q      <= ST_READ;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
  // Saturating count of cycles spent outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
    end else if (busy && (perf_busy_cycles != '1)) begin
      perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_v_shift_seq.sv
// Bench for riscv_v_shift_seq: register-file and shifter stand-ins plus writeback scoreboard.
// Latency: n/a.
// Backpressure: wb_ready driven by the stimulus to create writeback stalls.
module tb_riscv_v_shift_seq;

  localparam int DW  = 128;
  localparam int NO  = 5;
  localparam int RAW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_is_left, req_is_arith;
  logic [NO-1:0]  req_osize;
  logic [1:0]     req_lmul;
  logic [RAW-1:0] req_vd, req_vs1, req_vs2;
  logic           rf_rd_en;
  logic [RAW-1:0] rf_rd_addr_a, rf_rd_addr_b;
  logic [DW-1:0]  rf_rd_data_a, rf_rd_data_b;
  logic           sh_is_shift, sh_is_left, sh_is_arith;
  logic [NO-1:0]  sh_osize_vector, sh_is_greater_osize_vector;
  logic [DW-1:0]  sh_srca, sh_srcb, sh_result;
  logic           wb_valid, wb_ready, wb_last, busy;
  logic [RAW-1:0] wb_addr;
  logic [DW-1:0]  wb_data;
`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
  logic [31:0]    perf_busy_cycles;
`endif

  always #5 clk = ~clk;

  riscv_v_shift_seq dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .req_valid                  (req_valid),
    .req_ready                  (req_ready),
    .req_is_left                (req_is_left),
    .req_is_arith               (req_is_arith),
    .req_osize                  (req_osize),
    .req_lmul                   (req_lmul),
    .req_vd                     (req_vd),
    .req_vs1                    (req_vs1),
    .req_vs2                    (req_vs2),
    .rf_rd_en                   (rf_rd_en),
    .rf_rd_addr_a               (rf_rd_addr_a),
    .rf_rd_addr_b               (rf_rd_addr_b),
    .rf_rd_data_a               (rf_rd_data_a),
    .rf_rd_data_b               (rf_rd_data_b),
    .sh_is_shift                (sh_is_shift),
    .sh_is_left                 (sh_is_left),
    .sh_is_arith                (sh_is_arith),
    .sh_osize_vector            (sh_osize_vector),
    .sh_is_greater_osize_vector (sh_is_greater_osize_vector),
    .sh_srca                    (sh_srca),
    .sh_srcb                    (sh_srcb),
    .sh_result                  (sh_result),
    .wb_valid                   (wb_valid),
    .wb_ready                   (wb_ready),
    .wb_addr                    (wb_addr),
    .wb_data                    (wb_data),
    .wb_last                    (wb_last),
    .busy                       (busy)
`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
    ,
    .perf_busy_cycles           (perf_busy_cycles)
`endif
  );

  // Register file stand-in: data returns the cycle after the read strobe.
  logic [DW-1:0] rf [32];
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_data_a <= rf[rf_rd_addr_a];
      rf_rd_data_b <= rf[rf_rd_addr_b];
    end
  end

  // Shifter stand-in: per-element shift, amount taken modulo element width.
  function automatic logic [DW-1:0] shift_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [NO-1:0] oh, input logic left,
                                                input logic arith);
    int w;
    logic [DW-1:0] r;
    w = 8;
    for (int k = 0; k < NO; k++) if (oh[k]) w = 8 << k;
    r = '0;
    for (int e = 0; e < DW / w; e++) begin
      logic [DW-1:0] el, res, mask;
      int amt;
      mask = (w == DW) ? '1 : ((128'd1 << w) - 128'd1);
      el   = (b >> (e * w)) & mask;
      amt  = int'(a[e*w +: 7]) % w;
      if (left) res = (el << amt) & mask;
      else begin
        res = el >> amt;
        if (arith && el[w-1]) res = res | (~(mask >> amt) & mask);
      end
      r = r | (res << (e * w));
    end
    return r;
  endfunction

  assign sh_result = shift_model(sh_srca, sh_srcb, sh_osize_vector, sh_is_left, sh_is_arith);

  typedef struct packed {
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
    logic           last;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [RAW-1:0] a, input logic [DW-1:0] d, input logic l);
    wb_exp_t e;
    e.addr = a;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic           stalled;
  logic [RAW-1:0] held_addr;
  logic [DW-1:0]  held_data;
  logic           held_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_wb_valid_held", 128'(wb_valid), 128'(1));
        check("stall_wb_data_held", wb_data, held_data);
        check("stall_wb_addr_held", 128'(wb_addr), 128'(held_addr));
        check("stall_wb_last_held", 128'(wb_last), 128'(held_last));
        check("stall_no_rd_en", 128'(rf_rd_en), 128'(0));
      end
      if (wb_valid && wb_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wb: addr %0d data %0h, expected none", wb_addr, wb_data);
        end else begin
          wb_exp_t e;
          e = exp_q.pop_front();
          check("wb_addr", 128'(wb_addr), 128'(e.addr));
          check("wb_data", wb_data, e.data);
          check("wb_last", 128'(wb_last), 128'(e.last));
        end
      end else if (wb_valid) begin
        stalled   = 1'b1;
        held_addr = wb_addr;
        held_data = wb_data;
        held_last = wb_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic issue(input logic left, input logic arith, input logic [NO-1:0] osz,
                       input logic [1:0] lmul, input logic [RAW-1:0] vd,
                       input logic [RAW-1:0] vs1, input logic [RAW-1:0] vs2);
    wait_idle();
    @(posedge clk); #1;
    req_is_left  = left;
    req_is_arith = arith;
    req_osize    = osz;
    req_lmul     = lmul;
    req_vd       = vd;
    req_vs1      = vs1;
    req_vs2      = vs2;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  task automatic exec_ctl(input string name, input logic [NO-1:0] exp_oh, input logic [NO-1:0] exp_gt);
    int n;
    n = 0;
    while (!sh_is_shift && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_osize_vector"}, 128'(sh_osize_vector), 128'(exp_oh));
    check({name, "_greater_vector"}, 128'(sh_is_greater_osize_vector), 128'(exp_gt));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, lat, cnt;
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_left = 1'b0; req_is_arith = 1'b0;
    req_osize = '0; req_lmul = '0; req_vd = '0; req_vs1 = '0; req_vs2 = '0;
    wb_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1]  = {16{8'h01}};
    rf[2]  = {16{8'h80}};
    rf[3]  = {16{8'h81}};
    rf[4]  = {16{8'h09}};
    for (int i = 0; i < 8; i++) rf[16+i] = {16{8'(16 + i)}};
    rf[24] = {8{16'h8000}};
    rf[25] = {8{16'h4000}};
    rf[26] = {8{16'h0004}};
    rf[27] = {8{16'h0001}};
    rf[28] = {2{64'h1}};
    rf[29] = {2{64'd4}};

    // Reset state.
    repeat (2) @(posedge clk); #1;
    check("rst_wb_valid", 128'(wb_valid), 128'(0));
    check("rst_rf_rd_en", 128'(rf_rd_en), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_wb_data", wb_data, 128'(0));
    check("rst_wb_addr", 128'(wb_addr), 128'(0));
    check("rst_wb_last", 128'(wb_last), 128'(0));
`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
    check("rst_perf", 128'(perf_busy_cycles), 128'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-pass logical right shift of bytes 0x80 by 1, with step-by-step control checks.
    push(5'd5, {16{8'h40}}, 1'b1);
    issue(1'b0, 1'b0, 5'b00001, 2'd0, 5'd5, 5'd1, 5'd2);
    check("read_rd_en", 128'(rf_rd_en), 128'(1));
    check("read_addr_a", 128'(rf_rd_addr_a), 128'(1));
    check("read_addr_b", 128'(rf_rd_addr_b), 128'(2));
    check("read_no_shift", 128'(sh_is_shift), 128'(0));
    check("read_srca_zero", sh_srca, 128'(0));
    check("read_srcb_zero", sh_srcb, 128'(0));
    check("busy_req_ready", 128'(req_ready), 128'(0));
    check("busy_flag", 128'(busy), 128'(1));
    @(posedge clk); #1;
    check("exec_is_shift", 128'(sh_is_shift), 128'(1));
    check("exec_srca", sh_srca, {16{8'h01}});
    check("exec_srcb", sh_srcb, {16{8'h80}});
    check("exec_rd_en_low", 128'(rf_rd_en), 128'(0));
    lat = 2;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wb_valid && lat < 10);
    check("first_wb_latency", 128'(lat), 128'(3));
    wait_idle();

    // LMUL=8 with destination wrap 28..31,0..3; zero shift amounts pass data through.
    for (int i = 0; i < 8; i++) push(5'(28 + i), {16{8'(16 + i)}}, (i == 7));
    issue(1'b0, 1'b0, 5'b10000, 2'd3, 5'd28, 5'd8, 5'd16);
    n = 1;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    check("lmul8_busy_cycles", 128'(n), 128'(24));

    // Arithmetic right, 16-bit elements, writeback stalled for 10 cycles on the second pass.
    push(5'd0, {8{16'hF800}}, 1'b0);
    push(5'd1, {8{16'h2000}}, 1'b1);
    issue(1'b0, 1'b1, 5'b00010, 2'd1, 5'd0, 5'd26, 5'd24);
    n = 0;
    while (!(wb_valid && wb_addr == 5'd1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    wb_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    wb_ready = 1'b1;
    wait_idle();

    // Non-one-hot size falls back to bytes; 64-bit size control vectors.
    push(5'd7, {16{8'h02}}, 1'b1);
    issue(1'b1, 1'b0, 5'b00110, 2'd0, 5'd7, 5'd4, 5'd3);
    exec_ctl("osize_illegal", 5'b00001, 5'b00001);
    wait_idle();
    push(5'd9, {2{64'h10}}, 1'b1);
    issue(1'b1, 1'b0, 5'b01000, 2'd0, 5'd9, 5'd29, 5'd28);
    exec_ctl("osize_64", 5'b01000, 5'b01111);
    wait_idle();

    // Reset during EXEC of the second of four passes abandons the instruction.
    push(5'd12, {16{8'h10}}, 1'b0);
    issue(1'b0, 1'b0, 5'b10000, 2'd2, 5'd12, 5'd8, 5'd16);
    cnt = 0;
    n = 0;
    while (cnt < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (sh_is_shift) cnt++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_wb_valid", 128'(wb_valid), 128'(0));
    check("midrst_rf_rd_en", 128'(rf_rd_en), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_is_shift", 128'(sh_is_shift), 128'(0));
    check("midrst_wb_addr", 128'(wb_addr), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("postrst_no_rd_en", 128'(rf_rd_en), 128'(0));
      check("postrst_no_wb", 128'(wb_valid), 128'(0));
    end
    check("postrst_req_ready", 128'(req_ready), 128'(1));
    check("sb_drained_after_reset", 128'(exp_q.size()), 128'(0));
`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
    check("postrst_perf", 128'(perf_busy_cycles), 128'(0));
`endif

    // Recovery: LMUL=2 with destination wrap 30,31.
    push(5'd30, {16{8'h12}}, 1'b0);
    push(5'd31, {16{8'h13}}, 1'b1);
    issue(1'b0, 1'b0, 5'b10000, 2'd1, 5'd30, 5'd8, 5'd18);
    wait_idle();
`ifdef RISCV_V_SHIFT_SEQ_PERF_CNT_EN
    check("perf_lmul2", 128'(perf_busy_cycles), 128'(6));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained_final", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
